// File: rtl/sd_cmd_master_pkg.sv
// Shared constants for the SD command master: one-hot state encodings,
// response-type codes and lengths, setting-word field offsets, error codes.
package sd_cmd_master_pkg;

    // One-hot FSM encodings
    localparam logic [7:0] ST_IDLE   = 8'h01;
    localparam logic [7:0] ST_ARM    = 8'h02;
    localparam logic [7:0] ST_REQ    = 8'h04;
    localparam logic [7:0] ST_REL    = 8'h08;
    localparam logic [7:0] ST_WAIT   = 8'h10;
    localparam logic [7:0] ST_EACK   = 8'h20;
    localparam logic [7:0] ST_FINISH = 8'h40;
    localparam logic [7:0] ST_ABORT  = 8'h80;

    // Response types
    localparam logic [1:0] RSP_NONE  = 2'b00;
    localparam logic [1:0] RSP_SHORT = 2'b01;
    localparam logic [1:0] RSP_LONG  = 2'b10;
    localparam logic [1:0] RSP_BUSY  = 2'b11;

    // Response sizes in bits as carried in the setting word
    localparam logic [6:0] RSP_LEN_SHORT = 7'd40;
    localparam logic [6:0] RSP_LEN_LONG  = 7'd127;

    // Setting-word field offsets
    localparam int SET_LEN_LSB  = 0;
    localparam int SET_CRC_BIT  = 7;
    localparam int SET_DLY_LSB  = 8;
    localparam int SET_WR_BIT   = 11;
    localparam int SET_RD_BIT   = 12;
    localparam int SET_WSEL_LSB = 13;

    // Engine status bits
    localparam int STAT_FINAL_BIT  = 6;
    localparam int STAT_CRC_OK_BIT = 5;

    // Error codes reported with done_o
    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_CRC = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    function automatic logic [6:0] rsp_len(input logic [1:0] t);
        case (t)
            RSP_SHORT, RSP_BUSY: rsp_len = RSP_LEN_SHORT;
            RSP_LONG:            rsp_len = RSP_LEN_LONG;
            default:             rsp_len = 7'd0;
        endcase
    endfunction

    function automatic logic [15:0] build_setting(
        input logic [1:0] t,
        input logic       crc,
        input logic [2:0] dly,
        input logic       wr,
        input logic       rd,
        input logic [1:0] ws
    );
        logic [15:0] s;
        s = '0;
        s[SET_LEN_LSB +: 7]  = rsp_len(t);
        s[SET_CRC_BIT]       = crc;
        s[SET_DLY_LSB +: 3]  = dly;
        s[SET_WR_BIT]        = wr;
        s[SET_RD_BIT]        = rd;
        s[SET_WSEL_LSB +: 2] = ws;
        return s;
    endfunction

endpackage

// File: rtl/sd_cmd_master_sd_hs_sync.sv
// Two-flop synchronizer for the REQ/ACK handshake lines coming back
// from the serial engine.
module sd_hs_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // Shift the raw input through two flops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/sd_cmd_master.sv
// SD command master: latches one host command, runs the four-phase
// REQ/ACK handshake with the serial engine, consumes status events,
// captures the response and enforces a response timeout (abort via
// GO_IDLE_OUT). Optional build macro SD_CMD_RETRY_EN: one automatic
// retry of a command whose response failed its CRC check.
module sd_cmd_master
    import sd_cmd_master_pkg::*;
#(
    parameter int         TIMEOUT_W = 16,
    parameter logic [2:0] DLY_CYC   = 3'd7
) (
    input  logic                 SD_CLK_IN,
    input  logic                 RST_IN,
    input  logic                 start_i,
    input  logic [5:0]           cmd_idx_i,
    input  logic [31:0]          arg_i,
    input  logic [1:0]           rsp_type_i,
    input  logic                 crc_chk_i,
    input  logic                 blk_rd_i,
    input  logic                 blk_wr_i,
    input  logic [1:0]           word_sel_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           err_o,
    output logic [39:0]          rsp_o,
    output logic [15:0]          SETTING_OUT,
    output logic [39:0]          CMD_OUT,
    output logic                 REQ_OUT,
    input  logic                 ACK_IN,
    input  logic                 REQ_IN,
    output logic                 ACK_OUT,
    input  logic [15:0]          STATUS_IN,
    input  logic [39:0]          RSP_IN,
    output logic                 GO_IDLE_OUT
);

    logic                 w_ack_s;
    logic                 w_req_s;
    logic                 w_rsp_en;
    logic                 w_tmo_hit;
    logic                 w_unused;

    logic [7:0]           r_state;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_abort_cnt;
    logic                 r_final;
    logic                 r_crc_err;
    logic [1:0]           r_err;
    logic [39:0]          r_cmd;
    logic [15:0]          r_setting;
    logic [39:0]          r_rsp;
    logic [39:0]          r_rsp_stg;
`ifdef SD_CMD_RETRY_EN
    logic                 r_retried;
`endif

    sd_hs_sync u_sync_ack (
        .i_clk   (SD_CLK_IN),
        .i_rst_n (RST_IN),
        .i_d     (ACK_IN),
        .o_q     (w_ack_s)
    );

    sd_hs_sync u_sync_req (
        .i_clk   (SD_CLK_IN),
        .i_rst_n (RST_IN),
        .i_d     (REQ_IN),
        .o_q     (w_req_s)
    );

    // A zero-length response field means "no response": nothing to capture or check
    assign w_rsp_en  = (r_setting[SET_LEN_LSB +: 7] != 7'd0);
    assign w_tmo_hit = (timeout_i != '0) && (r_cnt == timeout_i);
    assign w_unused  = ^{STATUS_IN[15:7], STATUS_IN[4:0]};

    // Command sequencing FSM with timeout counter and response capture.
    // The response is staged during the final event and only committed on
    // FINISH, so an abort after the final event leaves rsp_o untouched.
    always_ff @(posedge SD_CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_abort_cnt <= 1'b0;
            r_final     <= 1'b0;
            r_crc_err   <= 1'b0;
            r_err       <= ERR_OK;
            r_cmd       <= '0;
            r_setting   <= '0;
            r_rsp       <= '0;
            r_rsp_stg   <= '0;
`ifdef SD_CMD_RETRY_EN
            r_retried   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_cmd     <= {2'b01, cmd_idx_i, arg_i};
                        r_setting <= build_setting(rsp_type_i, crc_chk_i, DLY_CYC,
                                                   blk_wr_i, blk_rd_i, word_sel_i);
                        r_final   <= 1'b0;
                        r_crc_err <= 1'b0;
                        r_err     <= ERR_OK;
`ifdef SD_CMD_RETRY_EN
                        r_retried <= 1'b0;
`endif
                        r_state   <= ST_ARM;
                    end
                end
                // Engine signals idle by holding ACK high
                ST_ARM: if (w_ack_s) r_state <= ST_REQ;
                ST_REQ: if (!w_ack_s) r_state <= ST_REL;
                ST_REL: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An event arriving on the expiry cycle takes priority
                    if (w_req_s) begin
                        r_cnt <= '0;
                        if (STATUS_IN[STAT_FINAL_BIT]) begin
                            r_final <= 1'b1;
                            if (w_rsp_en) begin
                                r_rsp_stg <= RSP_IN;
                                r_crc_err <= r_setting[SET_CRC_BIT] & ~STATUS_IN[STAT_CRC_OK_BIT];
                            end
                        end
                        r_state <= ST_EACK;
                    end else if (w_tmo_hit) begin
                        r_err       <= ERR_TMO;
                        r_abort_cnt <= 1'b0;
                        r_state     <= ST_ABORT;
                    end else begin
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                    end
                end
                ST_EACK: begin
                    if (!w_req_s) begin
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                        if (!r_final) begin
                            r_state <= ST_WAIT;
                        end else
`ifdef SD_CMD_RETRY_EN
                        if (r_crc_err && !r_retried) begin
                            // Replay the same latched words once, silently
                            r_retried <= 1'b1;
                            r_final   <= 1'b0;
                            r_crc_err <= 1'b0;
                            r_state   <= ST_ARM;
                        end else
`endif
                        begin
                            r_err   <= r_crc_err ? ERR_CRC : ERR_OK;
                            if (w_rsp_en) r_rsp <= r_rsp_stg;
                            r_state <= ST_FINISH;
                        end
                    end else if (w_tmo_hit) begin
                        r_err       <= ERR_TMO;
                        r_abort_cnt <= 1'b0;
                        r_state     <= ST_ABORT;
                    end else begin
                        r_cnt <= r_cnt + TIMEOUT_W'(1);
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                // GO_IDLE held for two cycles, then report through FINISH
                ST_ABORT: begin
                    if (r_abort_cnt) r_state <= ST_FINISH;
                    else             r_abort_cnt <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign done_o      = (r_state == ST_FINISH);
    assign err_o       = r_err;
    assign rsp_o       = r_rsp;
    assign SETTING_OUT = r_setting;
    assign CMD_OUT     = r_cmd;
    assign REQ_OUT     = (r_state == ST_REQ);
    assign ACK_OUT     = (r_state == ST_EACK);
    assign GO_IDLE_OUT = (r_state == ST_ABORT);

endmodule

// File: tb/tb_sd_cmd_master.sv
// Directed testbench for sd_cmd_master. The serial engine is modelled by
// a command-handshake responder plus event tasks; completions are checked
// against a scoreboard queue filled when each command is issued.
module tb_sd_cmd_master;

    // Delay field zero so setting vectors such as 16'h10A8 apply directly
    localparam logic [2:0] DLY = 3'd0;

    typedef struct {
        logic [1:0]  err;
        logic [39:0] rsp;
    } exp_t;

    logic        SD_CLK_IN, RST_IN, start_i, crc_chk_i, blk_rd_i, blk_wr_i;
    logic [5:0]  cmd_idx_i;
    logic [31:0] arg_i;
    logic [1:0]  rsp_type_i, word_sel_i;
    logic [15:0] timeout_i;
    logic        busy_o, done_o, REQ_OUT, ACK_IN, REQ_IN, ACK_OUT, GO_IDLE_OUT;
    logic [1:0]  err_o;
    logic [39:0] rsp_o, CMD_OUT, RSP_IN;
    logic [15:0] SETTING_OUT, STATUS_IN;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   req_cnt = 0;
    logic req_prev = 1'b0;
    exp_t sb[$];
    logic [39:0] model_rsp;

    sd_cmd_master #(.TIMEOUT_W(16), .DLY_CYC(DLY)) dut (
        .SD_CLK_IN(SD_CLK_IN), .RST_IN(RST_IN), .start_i(start_i),
        .cmd_idx_i(cmd_idx_i), .arg_i(arg_i), .rsp_type_i(rsp_type_i),
        .crc_chk_i(crc_chk_i), .blk_rd_i(blk_rd_i), .blk_wr_i(blk_wr_i),
        .word_sel_i(word_sel_i), .timeout_i(timeout_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .rsp_o(rsp_o),
        .SETTING_OUT(SETTING_OUT), .CMD_OUT(CMD_OUT), .REQ_OUT(REQ_OUT),
        .ACK_IN(ACK_IN), .REQ_IN(REQ_IN), .ACK_OUT(ACK_OUT),
        .STATUS_IN(STATUS_IN), .RSP_IN(RSP_IN), .GO_IDLE_OUT(GO_IDLE_OUT)
    );

    initial begin
        SD_CLK_IN = 1'b0;
        forever #5 SD_CLK_IN = ~SD_CLK_IN;
    end

    always @(posedge SD_CLK_IN) cyc <= cyc + 1;

    // Count rising edges of REQ_OUT
    always @(negedge SD_CLK_IN) begin
        req_prev <= REQ_OUT;
        if (REQ_OUT && !req_prev) req_cnt <= req_cnt + 1;
    end

    // Engine command side: ACK high while idle, low once REQ is seen
    initial begin
        ACK_IN = 1'b1;
        forever begin
            @(negedge SD_CLK_IN);
            ACK_IN = !REQ_OUT;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return REQ_OUT;
            1:       return ACK_OUT;
            2:       return GO_IDLE_OUT;
            default: return done_o;
        endcase
    endfunction

    // Wait (at negedges) until the selected output equals val; bounded
    task automatic wait_for(input int w, input logic val, input string tag);
        int n;
        n = 0;
        while (sel(w) !== val && n < 3000) begin
            @(negedge SD_CLK_IN);
            n++;
        end
        if (n >= 3000) check({tag, "_wait"}, 64'(sel(w)), 64'(val));
    endtask

    function automatic logic [15:0] exp_setting(input logic [1:0] rt, input logic crc,
                                                input logic rd, input logic wr, input logic [1:0] ws);
        logic [6:0] len;
        len = (rt == 2'b00) ? 7'd0 : (rt == 2'b10) ? 7'd127 : 7'd40;
        return {1'b0, ws, rd, wr, DLY, crc, len};
    endfunction

    // Issue one command; queue its expected completion
    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                             input logic crc, input logic rd, input logic wr, input logic [1:0] ws,
                             input logic [15:0] tmo, input logic [1:0] e_err, input logic [39:0] e_rsp,
                             input string tag);
        exp_t e;
        @(negedge SD_CLK_IN);
        cmd_idx_i = idx; arg_i = arg; rsp_type_i = rt; crc_chk_i = crc;
        blk_rd_i = rd; blk_wr_i = wr; word_sel_i = ws; timeout_i = tmo;
        start_i = 1'b1;
        @(negedge SD_CLK_IN);
        start_i = 1'b0;
        check({tag, "_cmd"}, 64'(CMD_OUT), 64'({2'b01, idx, arg}));
        check({tag, "_setting"}, 64'(SETTING_OUT), 64'(exp_setting(rt, crc, rd, wr, ws)));
        check({tag, "_busy"}, 64'(busy_o), 64'(1));
        if (rt != 2'b00 && e_err != 2'b10) model_rsp = e_rsp;
        e.err = e_err;
        e.rsp = model_rsp;
        sb.push_back(e);
    endtask

    // Engine status event: raise REQ_IN, wait for ACK, release
    task automatic engine_event(input logic fin, input logic crc_ok, input logic [39:0] rsp,
                                input string tag);
        @(negedge SD_CLK_IN);
        RSP_IN = rsp;
        STATUS_IN = {9'd0, fin, crc_ok, 5'd0};
        REQ_IN = 1'b1;
        wait_for(1, 1'b1, {tag, "_ack_hi"});
        REQ_IN = 1'b0;
        wait_for(1, 1'b0, {tag, "_ack_lo"});
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        wait_for(3, 1'b1, {tag, "_done"});
        if (done_o === 1'b1) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $error("FAIL %s_sb: observed done with empty queue expected none", tag);
            end else begin
                e = sb.pop_front();
                check({tag, "_err"}, 64'(err_o), 64'(e.err));
                check({tag, "_rsp"}, 64'(rsp_o), 64'(e.rsp));
                check({tag, "_busy_done"}, 64'(busy_o), 64'(0));
            end
            @(negedge SD_CLK_IN);
            check({tag, "_done_1cyc"}, 64'(done_o), 64'(0));
        end
    endtask

    initial begin
        int base, t0, t1;
        RST_IN = 1'b0; start_i = 1'b0; cmd_idx_i = '0; arg_i = '0; rsp_type_i = '0;
        crc_chk_i = 1'b0; blk_rd_i = 1'b0; blk_wr_i = 1'b0; word_sel_i = '0;
        timeout_i = '0; REQ_IN = 1'b0; STATUS_IN = '0; RSP_IN = '0;
        model_rsp = '0;

        // Reset state
        #12;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_hs", 64'({REQ_OUT, ACK_OUT, GO_IDLE_OUT, err_o}), 64'(0));
        check("rst_cmd", 64'(CMD_OUT), 64'(0));
        check("rst_setting", 64'(SETTING_OUT), 64'(0));
        check("rst_rsp", 64'(rsp_o), 64'(0));
        repeat (2) @(negedge SD_CLK_IN);
        RST_IN = 1'b1;
        repeat (3) @(negedge SD_CLK_IN);

        // No-response command: CMD word 40'h4000000000, rsp_o unchanged
        base = req_cnt;
        start_cmd(6'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0, 2'b00, 40'd0, "noresp");
        check("noresp_cmd_const", 64'(CMD_OUT), 64'h40_0000_0000);
        engine_event(1'b1, 1'b0, 40'hDE_ADBE_EF01, "noresp_ev");
        wait_done("noresp");
        check("noresp_reqs", 64'(req_cnt - base), 64'(1));

        // Short response, CRC good, with one intermediate event first
        base = req_cnt;
        start_cmd(6'd17, 32'h0000_0200, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 16'd0,
                  2'b00, 40'h11_0000_0900, "short");
        check("short_setting_const", 64'(SETTING_OUT), 64'h10A8);
        engine_event(1'b0, 1'b0, 40'h0, "short_ev0");
        check("short_midway_busy", 64'(busy_o), 64'(1));
        engine_event(1'b1, 1'b1, 40'h11_0000_0900, "short_ev1");
        wait_done("short");
        check("short_reqs", 64'(req_cnt - base), 64'(1));

        // Short response, CRC bad
        base = req_cnt;
        start_cmd(6'd17, 32'h0000_0200, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 16'd0,
                  2'b01, 40'h11_0000_0A00, "crcbad");
        engine_event(1'b1, 1'b0, 40'h11_0000_0A00, "crcbad_ev0");
`ifdef SD_CMD_RETRY_EN
        check("crcbad_no_early_done", 64'(done_o), 64'(0));
        engine_event(1'b1, 1'b0, 40'h11_0000_0A00, "crcbad_ev1");
        wait_done("crcbad");
        check("crcbad_reqs", 64'(req_cnt - base), 64'(2));
`else
        wait_done("crcbad");
        check("crcbad_reqs", 64'(req_cnt - base), 64'(1));
`endif

        // start_i while busy: ignored
        base = req_cnt;
        start_cmd(6'd2, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 1'b1, 2'b11, 16'd0,
                  2'b00, 40'hAB_CDEF_0123, "long");
        wait_for(0, 1'b1, "long_req");
        wait_for(0, 1'b0, "long_rel");
        cmd_idx_i = 6'd5; arg_i = 32'hFFFF_0000; rsp_type_i = 2'b01;
        start_i = 1'b1;
        @(negedge SD_CLK_IN);
        start_i = 1'b0;
        repeat (3) @(negedge SD_CLK_IN);
        check("busy_start_cmd", 64'(CMD_OUT), 64'({2'b01, 6'd2, 32'h1234_5678}));
        check("busy_start_setting", 64'(SETTING_OUT), 64'(exp_setting(2'b10, 1'b0, 1'b0, 1'b1, 2'b11)));
        engine_event(1'b1, 1'b1, 40'hAB_CDEF_0123, "long_ev");
        wait_done("long");
        check("busy_start_reqs", 64'(req_cnt - base), 64'(1));

        // Timeout 100 with no engine event: abort, rsp_o untouched.
        // REL is the first sample with REQ_OUT low; GO_IDLE rises 102 samples later.
        start_cmd(6'd13, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 16'd100,
                  2'b10, 40'h0, "tmo");
        wait_for(0, 1'b1, "tmo_req");
        wait_for(0, 1'b0, "tmo_rel");
        t0 = cyc;
        wait_for(2, 1'b1, "tmo_goidle");
        t1 = cyc;
        check("tmo_latency", 64'(t1 - t0), 64'(102));
        check("tmo_hs_forced", 64'({REQ_OUT, ACK_OUT}), 64'(0));
        @(negedge SD_CLK_IN);
        check("tmo_goidle_2nd", 64'(GO_IDLE_OUT), 64'(1));
        @(negedge SD_CLK_IN);
        check("tmo_goidle_end", 64'(GO_IDLE_OUT), 64'(0));
        wait_done("tmo");

        // Reset during WAIT_EVT: asynchronous return to reset values
        start_cmd(6'd8, 32'h0000_00AA, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0,
                  2'b00, 40'h08_0000_0001, "rstmid");
        wait_for(0, 1'b1, "rstmid_req");
        wait_for(0, 1'b0, "rstmid_rel");
        repeat (3) @(negedge SD_CLK_IN);
        #2 RST_IN = 1'b0;
        #1;
        check("rstmid_busy", 64'(busy_o), 64'(0));
        check("rstmid_cmd", 64'(CMD_OUT), 64'(0));
        check("rstmid_setting", 64'(SETTING_OUT), 64'(0));
        check("rstmid_rsp", 64'(rsp_o), 64'(0));
        sb.delete();
        model_rsp = '0;
        repeat (2) @(negedge SD_CLK_IN);
        check("rstmid_no_done", 64'(done_o), 64'(0));
        RST_IN = 1'b1;
        repeat (2) @(negedge SD_CLK_IN);

        // Fresh command after reset
        base = req_cnt;
        start_cmd(6'd55, 32'h0000_CAFE, 2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 16'd500,
                  2'b00, 40'h37_0000_0011, "fresh");
        engine_event(1'b1, 1'b1, 40'h37_0000_0011, "fresh_ev");
        wait_done("fresh");
        check("fresh_reqs", 64'(req_cnt - base), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
